dat_mem_stack: RTL
==================

Name: dat_mem_stack

Overview:
- Parametrised successor to the single-port 8x256 data memory.
- Keeps the following from the earlier block:
  - combinational load read;
  - clocked store;
  - mem_to_reg writeback mux that selects between memory read data and ALU result.
- Adds the following:
  - a hardware push/pop stack occupying the top STACK_DEPTH words;
  - full/empty/error flags;
  - a post-reset clear sequencer that zeroes every word.
- Sits between the ALU and the register-file writeback port.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 256, number of words; power of two.
- STACK_DEPTH, 16, words reserved for the stack at addresses DEPTH-1 down to DEPTH-STACK_DEPTH. Must satisfy 1 <= STACK_DEPTH < DEPTH.
- AW, $clog2(DEPTH), localparam, address width.
- CW, $clog2(STACK_DEPTH+1), localparam, stack-count width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dat_in  in  WIDTH  store/push data.
- alu_out  in  WIDTH  ALU result, forwarded when mem_to_reg=0.
- mem_to_reg  in  1  1: dat_out = core[addr]; 0: dat_out = alu_out.
- wr_en  in  1  store core[addr] <= dat_in.
- addr  in  AW  load/store address.
- push  in  1  push dat_in onto the stack.
- pop  in  1  pop the stack; the popped value appears on dat_out in the same cycle.
- dat_out  out  WIDTH  writeback data (combinational).
- stk_cnt  out  CW  current stack occupancy, 0..STACK_DEPTH.
- stk_empty  out  1  stk_cnt==0.
- stk_full  out  1  stk_cnt==STACK_DEPTH.
- stk_err  out  1  registered one-cycle pulse for an illegal stack operation.
- busy  out  1  clear sequence in progress; all requests are ignored while high.

Behaviour:
- Reset:
  - rst_n low forces state=CLEAR, clr_ptr=0, stk_cnt=0, stk_err=0, busy=1.
  - Memory contents are not reset directly.
  - Reset asserted mid-CLEAR restarts the sweep at word 0.
- FSM: two states, CLEAR and RUN.
  - CLEAR:
    - Each cycle writes core[clr_ptr] <= 0, then clr_ptr++.
    - After the write to word DEPTH-1, go to RUN. Total DEPTH cycles after rst_n release.
    - busy=1 throughout. wr_en/push/pop are ignored with no error. dat_out=0.
  - RUN: busy=0, and busy stays 0 until the next reset.
- Stack addressing:
  - Top-of-stack (TOS) address = DEPTH - stk_cnt (valid when stk_cnt>0).
  - Next-free address = DEPTH-1-stk_cnt.
  - Arithmetic is done in AW bits; no wrap is possible within legal counts.
- Request priority in RUN: push/pop > wr_en, because there is one write port.
  - A store coinciding with push or pop is dropped silently.
- dat_out:
  - If pop=1 and stk_cnt>0: dat_out = core[TOS], regardless of mem_to_reg.
  - If pop=1 and stk_cnt=0: dat_out = 0.
  - Otherwise: dat_out = mem_to_reg ? core[addr] : alu_out.
- Push only, not full: core[next-free] <= dat_in; stk_cnt++.
- Push only, full: no write, count unchanged, stk_err=1 next cycle.
- Pop only, not empty: stk_cnt--; memory is unchanged.
- Pop only, empty: count unchanged, stk_err=1 next cycle.
- Push and pop together, not empty (replace-top): core[TOS] <= dat_in; stk_cnt unchanged. dat_out shows the old TOS.
- Push and pop together, empty: no change, stk_err=1 next cycle.
- wr_en alone: core[addr] <= dat_in on the clock edge. A same-cycle load returns the old data (no write-through).
- Stores into the stack region are permitted unless the optional feature is compiled in.
- stk_err:
  - High for exactly one cycle per offending request.
  - Back-to-back offending requests give a continuously high stk_err.

Optional Feature:
- Macro: DAT_MEM_STACK_GUARD_EN.
- When defined:
  - wr_en with addr >= DEPTH-STACK_DEPTH, with no push/pop in the same cycle, is blocked and pulses stk_err next cycle.
  - Loads from the stack region with mem_to_reg=1 return 0.
- When undefined: the stack region is ordinary memory for loads and stores, and no guard logic is generated.

Decomposition:
- Shared package dat_mem_pkg holds:
  - state enum typedef (CLEAR, RUN);
  - default WIDTH/DEPTH/STACK_DEPTH constants;
  - a function computing the stack base address.
- One sub-module: dat_mem_stack_ctrl. It holds the stack count register, full/empty/err logic and TOS/next-free address generation.
- The memory array, clear FSM and output mux stay in the top level.

Test Plan:
- Clear sweep:
  - Stimulus: release rst_n with defaults.
  - Response: busy high for exactly 256 cycles, then low.
  - Loads of addr 0x00, 0x7F and 0xFF with mem_to_reg=1 return 0x00.
  - A wr_en issued during busy leaves the target word at 0.
- Load/store and mux:
  - Stimulus: store 0xA5 to 0x10, then load 0x10 with mem_to_reg=1, then again with mem_to_reg=0 and alu_out=0x3C.
  - Response: dat_out=0xA5, then dat_out=0x3C.
  - A same-cycle load during the store returns the old value.
- Stack order and flags:
  - Stimulus: push 0x01..0x10 (16 pushes), then pop 16 times.
  - Response: stk_full asserts after the 16th push; a 17th push pulses stk_err and leaves stk_cnt=16.
  - Pops return 0x10 down to 0x01; stk_empty asserts at the end.
  - An extra pop returns 0 and pulses stk_err.
- Simultaneous operations:
  - Stimulus: with stk_cnt=2, TOS=0x22, assert push+pop with dat_in=0x99; then pop.
  - Response: the first cycle's dat_out=0x22 and stk_cnt stays 2; the next pop returns 0x99.
  - Stimulus: push with wr_en to addr 0x05.
  - Response: core[0x05] is unchanged.
- Reset mid-operation:
  - Stimulus: stk_cnt=5, pulse rst_n low for 1 cycle, first asynchronously and then again at clr_ptr=100.
  - Response: stk_cnt=0 and busy=1 immediately on assertion; the sweep restarts and busy lasts the full 256 cycles after release.
- Guard, with DAT_MEM_STACK_GUARD_EN defined:
  - Stimulus: store 0x77 to 0xF5.
  - Response: stk_err pulses and core[0xF5] is unchanged.
  - Without the macro, the same store succeeds and the load returns 0x77.

Source files
------------

// File: rtl/dat_mem_pkg.sv
// Shared types and defaults for the data memory with hardware stack.
// The stack occupies the top STACK_DEPTH words of the array.
package dat_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_DEPTH       = 256;
    localparam int DEF_STACK_DEPTH = 16;

    // Lowest address that belongs to the stack region.
    function automatic int stack_base(input int depth, input int stack_depth);
        return depth - stack_depth;
    endfunction

endpackage

// File: rtl/dat_mem_stack_ctrl.sv
// Stack bookkeeping: occupancy count, full/empty/error flags and the
// top-of-stack / next-free addresses used by the shared write port.
module dat_mem_stack_ctrl
    import dat_mem_pkg::*;
#(
    parameter int  DEPTH       = DEF_DEPTH,
    parameter int  STACK_DEPTH = DEF_STACK_DEPTH,
    localparam int AW          = $clog2(DEPTH),
    localparam int CW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          push,
    input  logic          pop,
    input  logic          guard_err,
    output logic [CW-1:0] stk_cnt,
    output logic          stk_empty,
    output logic          stk_full,
    output logic          stk_err,
    output logic          pop_hit,
    output logic          stk_we,
    output logic [AW-1:0] stk_addr,
    output logic [AW-1:0] tos_addr
);

    logic [AW-1:0] free_addr;
    logic          do_push;
    logic          do_pop;
    logic          do_repl;
    logic          err_next;

    assign stk_empty = (stk_cnt == '0);
    assign stk_full  = (stk_cnt == CW'(STACK_DEPTH));

    // Modulo-2^AW arithmetic: DEPTH itself truncates to zero, so DEPTH - cnt lands correctly.
    assign tos_addr  = AW'(DEPTH) - AW'(stk_cnt);
    assign free_addr = AW'(DEPTH - 1) - AW'(stk_cnt);

    assign do_push = run & push & ~pop & ~stk_full;
    assign do_pop  = run & pop & ~push & ~stk_empty;
    assign do_repl = run & push & pop & ~stk_empty;

    assign err_next = run & ((pop & stk_empty) | (push & ~pop & stk_full) | guard_err);

    assign pop_hit  = pop & ~stk_empty;
    assign stk_we   = do_push | do_repl;
    assign stk_addr = do_repl ? tos_addr : free_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stk_cnt <= '0;
            stk_err <= 1'b0;
        end else begin
            stk_err <= err_next;
            if (do_push) begin
                stk_cnt <= stk_cnt + CW'(1);
            end else if (do_pop) begin
                stk_cnt <= stk_cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/dat_mem_stack.sv
// Data memory with combinational load, clocked store, writeback mux, hardware
// stack and post-reset clear sweep. Optional stack guard: DAT_MEM_STACK_GUARD_EN.
module dat_mem_stack
    import dat_mem_pkg::*;
#(
    parameter int  WIDTH       = DEF_WIDTH,
    parameter int  DEPTH       = DEF_DEPTH,
    parameter int  STACK_DEPTH = DEF_STACK_DEPTH,
    localparam int AW          = $clog2(DEPTH),
    localparam int CW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] dat_in,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             mem_to_reg,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] dat_out,
    output logic [CW-1:0]    stk_cnt,
    output logic             stk_empty,
    output logic             stk_full,
    output logic             stk_err,
    output logic             busy
);

    state_t           state;
    state_t           state_next;
    logic [AW-1:0]    clr_ptr;
    logic [WIDTH-1:0] core [DEPTH];

    logic             run;
    logic             guard_err;
    logic             store_ok;
    logic             pop_hit;
    logic             stk_we;
    logic [AW-1:0]    stk_addr;
    logic [AW-1:0]    tos_addr;

    assign busy = (state == CLEAR);
    assign run  = ~busy;

`ifdef DAT_MEM_STACK_GUARD_EN
    logic in_stack;
    assign in_stack  = (addr >= AW'(stack_base(DEPTH, STACK_DEPTH)));
    assign guard_err = run & wr_en & ~push & ~pop & in_stack;
    assign store_ok  = run & wr_en & ~push & ~pop & ~in_stack;
`else
    assign guard_err = 1'b0;
    assign store_ok  = run & wr_en & ~push & ~pop;
`endif

    dat_mem_stack_ctrl #(
        .DEPTH       (DEPTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .push      (push),
        .pop       (pop),
        .guard_err (guard_err),
        .stk_cnt   (stk_cnt),
        .stk_empty (stk_empty),
        .stk_full  (stk_full),
        .stk_err   (stk_err),
        .pop_hit   (pop_hit),
        .stk_we    (stk_we),
        .stk_addr  (stk_addr),
        .tos_addr  (tos_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) begin
                clr_ptr <= clr_ptr + AW'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        if (state == CLEAR && clr_ptr == AW'(DEPTH - 1)) begin
            state_next = RUN;
        end
    end

    // Single write port: clear sweep, then stack traffic, then plain stores.
    always_ff @(posedge clk) begin
        if (busy) begin
            core[clr_ptr] <= '0;
        end else if (stk_we) begin
            core[stk_addr] <= dat_in;
        end else if (store_ok) begin
            core[addr] <= dat_in;
        end
    end

    always_comb begin
        dat_out = '0;
        if (run) begin
            if (pop) begin
                if (pop_hit) begin
                    dat_out = core[tos_addr];
                end
            end else if (mem_to_reg) begin
`ifdef DAT_MEM_STACK_GUARD_EN
                dat_out = in_stack ? '0 : core[addr];
`else
                dat_out = core[addr];
`endif
            end else begin
                dat_out = alu_out;
            end
        end
    end

endmodule
